// File: rtl/llr_user_scheduler.sv
// Per-symbol user sequencer: walks the user table, restarts the LLR datapath FSM and counts strobes per user.
// Latency: sym_start -> LOAD in 1 cycle, RUN after FSM_RST_CYCLES more; no backpressure, stray strobes only flag an error.
module llr_user_scheduler #(
    parameter int MAX_USERS      = 8,
    parameter int FSM_RST_CYCLES = 2
) (
    input  logic                         i_core_clk,
    input  logic                         i_rx_rstn,
    input  logic                         i_cfg_wr_en,
    input  logic [$clog2(MAX_USERS)-1:0] i_cfg_wr_addr,
    input  logic [15:0]                  i_cfg_re_amounts,
    input  logic [15:0]                  i_cfg_iq_noise_rate,
    input  logic                         i_sym_start,
    input  logic [4:0]                   i_user_num,
    input  logic                         i_data_strobe,
    output logic                         o_rx_fsm_rstn,
    output logic [15:0]                  o_cur_user_re_amounts,
    output logic [15:0]                  o_user_iq_noise_rate,
    output logic [$clog2(MAX_USERS)-1:0] o_user_idx,
    output logic                         o_busy,
    output logic                         o_user_done,
    output logic                         o_sym_done,
    output logic                         o_err_cfg,
    output logic                         o_err_strobe
);
    localparam int         AW       = $clog2(MAX_USERS);
    localparam logic [4:0] MAX_NUM  = 5'(MAX_USERS);
    localparam logic [3:0] RST_LAST = 4'(FSM_RST_CYCLES - 1);

    typedef struct packed {
        logic [15:0] re_amounts;
        logic [15:0] iq_noise_rate;
    } user_cfg_t;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FRST, S_RUN, S_NEXT, S_DONE} state_t;

    user_cfg_t     cfg_tbl [MAX_USERS];
    user_cfg_t     cur_cfg;
    state_t        state, state_nxt;
    logic [AW-1:0] idx_nxt;
    logic [4:0]    user_num, user_num_nxt;
    logic [16:0]   exp_strb, exp_strb_nxt;
    logic [16:0]   strb_cnt, strb_cnt_nxt;
    logic [3:0]    rst_cnt, rst_cnt_nxt;
    logic [15:0]   cur_re_nxt, cur_rate_nxt;
    logic          bad_num_done, err_cfg_nxt;

    assign cur_cfg = cfg_tbl[o_user_idx];

    always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
        if (!i_rx_rstn) begin
            for (int i = 0; i < MAX_USERS; i++) cfg_tbl[i] <= '0;
        end else if (i_cfg_wr_en) begin
            cfg_tbl[i_cfg_wr_addr] <= '{re_amounts: i_cfg_re_amounts, iq_noise_rate: i_cfg_iq_noise_rate};
        end
    end

    always_comb begin
        state_nxt    = state;
        idx_nxt      = o_user_idx;
        user_num_nxt = user_num;
        exp_strb_nxt = exp_strb;
        strb_cnt_nxt = strb_cnt;
        rst_cnt_nxt  = rst_cnt;
        cur_re_nxt   = o_cur_user_re_amounts;
        cur_rate_nxt = o_user_iq_noise_rate;
        bad_num_done = 1'b0;
        err_cfg_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_sym_start) begin
                    if (i_user_num == 5'd0 || i_user_num > MAX_NUM) begin
                        bad_num_done = 1'b1;
                    end else begin
                        user_num_nxt = i_user_num;
                        idx_nxt      = '0;
                        state_nxt    = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                cur_re_nxt   = cur_cfg.re_amounts;
                cur_rate_nxt = cur_cfg.iq_noise_rate;
                // Two REs per strobe; an odd RE count still needs a final strobe.
                exp_strb_nxt = ({1'b0, cur_cfg.re_amounts} + 17'd1) >> 1;
                strb_cnt_nxt = '0;
                rst_cnt_nxt  = '0;
                if (cur_cfg.re_amounts == 16'd0 || cur_cfg.iq_noise_rate == 16'd0) begin
                    err_cfg_nxt = 1'b1;
                    state_nxt   = S_NEXT;
                end else begin
                    state_nxt = S_FRST;
                end
            end
            S_FRST: begin
                if (rst_cnt == RST_LAST) state_nxt = S_RUN;
                else                     rst_cnt_nxt = rst_cnt + 4'd1;
            end
            S_RUN: begin
                if (i_data_strobe) begin
                    strb_cnt_nxt = strb_cnt + 17'd1;
                    if (strb_cnt + 17'd1 == exp_strb) state_nxt = S_NEXT;
                end
            end
            S_NEXT: begin
                if (5'(o_user_idx) == user_num - 5'd1) begin
                    state_nxt = S_DONE;
                end else begin
                    idx_nxt   = o_user_idx + AW'(1);
                    state_nxt = S_LOAD;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Flags are registered from the next state so each pulse lines up with the state it names.
    always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
        if (!i_rx_rstn) begin
            state                 <= S_IDLE;
            user_num              <= '0;
            exp_strb              <= '0;
            strb_cnt              <= '0;
            rst_cnt               <= '0;
            o_user_idx            <= '0;
            o_cur_user_re_amounts <= '0;
            o_user_iq_noise_rate  <= '0;
            o_rx_fsm_rstn         <= 1'b0;
            o_busy                <= 1'b0;
            o_user_done           <= 1'b0;
            o_sym_done            <= 1'b0;
            o_err_cfg             <= 1'b0;
            o_err_strobe          <= 1'b0;
        end else begin
            state                 <= state_nxt;
            user_num              <= user_num_nxt;
            exp_strb              <= exp_strb_nxt;
            strb_cnt              <= strb_cnt_nxt;
            rst_cnt               <= rst_cnt_nxt;
            o_user_idx            <= idx_nxt;
            o_cur_user_re_amounts <= cur_re_nxt;
            o_user_iq_noise_rate  <= cur_rate_nxt;
            o_rx_fsm_rstn         <= (state_nxt != S_FRST);
            o_busy                <= (state_nxt inside {S_LOAD, S_FRST, S_RUN, S_NEXT});
            o_user_done           <= (state_nxt == S_NEXT);
            o_sym_done            <= (state_nxt == S_DONE) || bad_num_done;
            o_err_cfg             <= err_cfg_nxt;
            o_err_strobe          <= i_data_strobe && (state != S_RUN);
        end
    end
endmodule

// File: tb/tb_llr_user_scheduler.sv
// Bench for llr_user_scheduler: a per-cycle expected timeline is built from the user table and
// the sequencing latencies, then replayed against the DUT with every output compared each cycle.
module tb_llr_user_scheduler;
    localparam int MAXU = 8;
    localparam int F    = 2;
    localparam int NC   = 4096;

    logic        tb_sclk = 1'b0;
    logic        rx_rstn = 1'b0;
    logic        cfg_wr_en = 1'b0;
    logic [2:0]  cfg_wr_addr = '0;
    logic [15:0] cfg_re_amounts = '0;
    logic [15:0] cfg_iq_noise_rate = '0;
    logic        sym_start = 1'b0;
    logic [4:0]  user_num = '0;
    logic        data_strobe = 1'b0;
    logic        rx_fsm_rstn;
    logic [15:0] cur_user_re_amounts;
    logic [15:0] user_iq_noise_rate;
    logic [2:0]  user_idx;
    logic        busy, user_done, sym_done, err_cfg, err_strobe;

    int n_checks = 0;
    int n_errors = 0;

    // Reference table and expected per-cycle timeline.
    int mdl_re [MAXU];
    int mdl_rate [MAXU];
    bit e_busy [NC], e_rstn [NC], e_udone [NC], e_sdone [NC], e_ecfg [NC], e_estb [NC];
    int e_idx [NC], e_re [NC], e_rate [NC];
    bit d_stb [NC], d_start [NC], d_wr [NC];
    int tl_len;
    bit wr_used;
    int wr_re_v, wr_rate_v;

    always #5 tb_sclk = ~tb_sclk;

    llr_user_scheduler #(.MAX_USERS(MAXU), .FSM_RST_CYCLES(F)) dut (
        .i_core_clk            (tb_sclk),
        .i_rx_rstn             (rx_rstn),
        .i_cfg_wr_en           (cfg_wr_en),
        .i_cfg_wr_addr         (cfg_wr_addr),
        .i_cfg_re_amounts      (cfg_re_amounts),
        .i_cfg_iq_noise_rate   (cfg_iq_noise_rate),
        .i_sym_start           (sym_start),
        .i_user_num            (user_num),
        .i_data_strobe         (data_strobe),
        .o_rx_fsm_rstn         (rx_fsm_rstn),
        .o_cur_user_re_amounts (cur_user_re_amounts),
        .o_user_iq_noise_rate  (user_iq_noise_rate),
        .o_user_idx            (user_idx),
        .o_busy                (busy),
        .o_user_done           (user_done),
        .o_sym_done            (sym_done),
        .o_err_cfg             (err_cfg),
        .o_err_strobe          (err_strobe)
    );

    task automatic write_cfg(input int addr, input int re, input int rate);
        cfg_wr_en         = 1'b1;
        cfg_wr_addr       = 3'(addr);
        cfg_re_amounts    = 16'(re);
        cfg_iq_noise_rate = 16'(rate);
        @(negedge tb_sclk);
        cfg_wr_en = 1'b0;
        mdl_re[addr]   = re;
        mdl_rate[addr] = rate;
    endtask

    // Cycle 0 is the cycle in which sym_start is presented.
    task automatic build(input int num, input int gap_pct, input bit inj_frst,
                         input bit inj_start, input bit inj_wr);
        int t, r, need, sent;
        for (int c = 0; c < NC; c++) begin
            e_busy[c] = 0; e_rstn[c] = 1; e_udone[c] = 0; e_sdone[c] = 0; e_ecfg[c] = 0; e_estb[c] = 0;
            e_idx[c] = -1; e_re[c] = -1; e_rate[c] = -1;
            d_stb[c] = 0; d_start[c] = 0; d_wr[c] = 0;
        end
        wr_used = 0;
        if (num == 0 || num > MAXU) begin
            e_sdone[1] = 1;
            tl_len = 4;
            return;
        end
        t = 1;
        for (int u = 0; u < num; u++) begin
            e_busy[t] = 1; e_idx[t] = u;
            if (mdl_re[u] == 0 || mdl_rate[u] == 0) begin
                e_busy[t+1] = 1; e_idx[t+1] = u; e_udone[t+1] = 1; e_ecfg[t+1] = 1;
                t += 2;
            end else begin
                for (int k = 1; k <= F; k++) begin
                    e_busy[t+k] = 1; e_rstn[t+k] = 0; e_idx[t+k] = u;
                    e_re[t+k] = mdl_re[u]; e_rate[t+k] = mdl_rate[u];
                end
                if (inj_frst && u == 0) begin d_stb[t+1] = 1; e_estb[t+2] = 1; end
                if (inj_start && u == 0) d_start[t+F+1] = 1;
                if (inj_wr && u == 0) begin
                    d_wr[t+F+1] = 1; wr_used = 1;
                    wr_re_v = int'($urandom_range(40, 1)); wr_rate_v = int'($urandom_range(7, 1));
                end
                need = (mdl_re[u] + 1) / 2;
                r = t + F + 1;
                sent = 0;
                while (sent < need) begin
                    e_busy[r] = 1; e_idx[r] = u; e_re[r] = mdl_re[u]; e_rate[r] = mdl_rate[u];
                    if (int'($urandom_range(99)) >= gap_pct) begin d_stb[r] = 1; sent++; end
                    r++;
                end
                e_busy[r] = 1; e_idx[r] = u; e_udone[r] = 1;
                t = r + 1;
            end
        end
        e_sdone[t] = 1;
        tl_len = t + 3;
    endtask

    // Entered and left at a negedge; stops early (before driving) at cycle stop_c.
    task automatic run_tl(input int num, input int stop_c, input string tag);
        logic [5:0] obs, exp_v;
        for (int c = 0; c < tl_len; c++) begin
            obs   = {busy, rx_fsm_rstn, user_done, sym_done, err_cfg, err_strobe};
            exp_v = {e_busy[c], e_rstn[c], e_udone[c], e_sdone[c], e_ecfg[c], e_estb[c]};
            n_checks++;
            if (obs !== exp_v) begin
                n_errors++;
                $display("FAIL %s ctl cyc %0d: got %b want %b (busy,rstn,udone,sdone,ecfg,estb)", tag, c, obs, exp_v);
            end
            if (e_idx[c] >= 0) begin
                n_checks++;
                if (user_idx !== 3'(e_idx[c])) begin
                    n_errors++;
                    $display("FAIL %s idx cyc %0d: got %0d want %0d", tag, c, user_idx, e_idx[c]);
                end
            end
            if (e_re[c] >= 0) begin
                n_checks++;
                if ({cur_user_re_amounts, user_iq_noise_rate} !== {16'(e_re[c]), 16'(e_rate[c])}) begin
                    n_errors++;
                    $display("FAIL %s cfg cyc %0d: got re=%0d rate=%0d want re=%0d rate=%0d",
                             tag, c, cur_user_re_amounts, user_iq_noise_rate, e_re[c], e_rate[c]);
                end
            end
            if (c == stop_c) return;
            sym_start   = (c == 0) || d_start[c];
            user_num    = 5'(num);
            data_strobe = d_stb[c];
            cfg_wr_en   = d_wr[c];
            if (d_wr[c]) begin
                cfg_wr_addr = 3'd0; cfg_re_amounts = 16'(wr_re_v); cfg_iq_noise_rate = 16'(wr_rate_v);
            end
            @(negedge tb_sclk);
        end
        sym_start = 1'b0; data_strobe = 1'b0; cfg_wr_en = 1'b0;
        if (wr_used) begin mdl_re[0] = wr_re_v; mdl_rate[0] = wr_rate_v; end
    endtask

    task automatic test_reset();
        logic [57:0] all_o;
        repeat (3) @(negedge tb_sclk);
        all_o = {rx_fsm_rstn, cur_user_re_amounts, user_iq_noise_rate, user_idx,
                 busy, user_done, sym_done, err_cfg, err_strobe, 11'd0};
        n_checks++;
        if (all_o !== 58'd0) begin
            n_errors++;
            $display("FAIL reset_vals: got %h want 0", all_o);
        end
        rx_rstn = 1'b1;
        @(negedge tb_sclk);
        n_checks++;
        if ({rx_fsm_rstn, busy} !== 2'b10) begin
            n_errors++;
            $display("FAIL reset_release: got rstn,busy=%b want 10", {rx_fsm_rstn, busy});
        end
        for (int i = 0; i < MAXU; i++) begin mdl_re[i] = 0; mdl_rate[i] = 0; end
        build(1, 0, 0, 0, 0);
        run_tl(1, -1, "reset_tbl_clear");
    endtask

    task automatic test_long_user();
        write_cfg(0, 1797, 6);
        build(1, 0, 0, 0, 0);
        run_tl(1, -1, "long_user");
    endtask

    task automatic test_back_to_back();
        write_cfg(0, 4, 6); write_cfg(1, 5, 6); write_cfg(2, 2, 6);
        build(3, 0, 0, 1, 0);
        run_tl(3, -1, "back_to_back");
    endtask

    task automatic test_skip_user();
        write_cfg(0, 7, 3); write_cfg(1, 0, 6); write_cfg(2, 3, 2);
        build(3, 20, 0, 0, 0);
        run_tl(3, -1, "skip_re0");
        write_cfg(1, 9, 0);
        build(3, 0, 0, 0, 0);
        run_tl(3, -1, "skip_rate0");
    endtask

    task automatic test_stray_strobe();
        data_strobe = 1'b1;
        @(negedge tb_sclk);
        data_strobe = 1'b0;
        n_checks++;
        if ({err_strobe, busy} !== 2'b10) begin
            n_errors++;
            $display("FAIL idle_strobe: got estb,busy=%b want 10", {err_strobe, busy});
        end
        @(negedge tb_sclk);
        n_checks++;
        if (err_strobe !== 1'b0) begin
            n_errors++;
            $display("FAIL idle_strobe_clear: got %b want 0", err_strobe);
        end
        write_cfg(0, 6, 6); write_cfg(1, 3, 5);
        build(2, 10, 1, 1, 0);
        run_tl(2, -1, "frst_strobe");
    endtask

    task automatic test_bad_num();
        build(0, 0, 0, 0, 0);
        run_tl(0, -1, "num_zero");
        build(MAXU + 1, 0, 0, 0, 0);
        run_tl(MAXU + 1, -1, "num_over");
    endtask

    task automatic test_reset_mid_run();
        write_cfg(0, 1797, 6);
        build(1, 0, 0, 0, 0);
        run_tl(1, 1 + F + 1 + 400, "mid_run_pre");
        rx_rstn = 1'b0; data_strobe = 1'b0; sym_start = 1'b0;
        #1;
        n_checks++;
        if ({rx_fsm_rstn, busy} !== 2'b00) begin
            n_errors++;
            $display("FAIL async_rst: got rstn,busy=%b want 00", {rx_fsm_rstn, busy});
        end
        repeat (2) begin
            @(negedge tb_sclk);
            n_checks++;
            if ({rx_fsm_rstn, busy, user_done, sym_done} !== 4'b0000) begin
                n_errors++;
                $display("FAIL rst_hold: got rstn,busy,udone,sdone=%b want 0000",
                         {rx_fsm_rstn, busy, user_done, sym_done});
            end
        end
        rx_rstn = 1'b1;
        @(negedge tb_sclk);
        for (int i = 0; i < MAXU; i++) begin mdl_re[i] = 0; mdl_rate[i] = 0; end
        write_cfg(0, 1797, 6);
        build(1, 0, 0, 0, 0);
        run_tl(1, -1, "mid_run_restart");
    endtask

    task automatic test_random();
        int num;
        for (int s = 0; s < 6; s++) begin
            for (int i = 0; i < MAXU; i++)
                write_cfg(i, ($urandom_range(9) == 0) ? 0 : int'($urandom_range(40, 1)),
                          ($urandom_range(9) == 0) ? 0 : int'($urandom_range(7, 1)));
            num = int'($urandom_range(MAXU, 1));
            build(num, 30, bit'($urandom_range(1)), bit'($urandom_range(1)), bit'($urandom_range(1)));
            run_tl(num, -1, $sformatf("random%0d", s));
        end
    endtask

    initial begin
        test_reset();
        test_long_user();
        test_back_to_back();
        test_skip_user();
        test_stray_strobe();
        test_bad_num();
        test_reset_mid_run();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/llr_user_scheduler.md
# llr_user_scheduler

Per-symbol user sequencer for the slow-PHY-to-LLR datapath. It holds a small user configuration table. On each symbol start it walks users 0..N-1 in order: it presents each user's RE count and IQ/noise rate to the datapath, restarts the datapath FSM through its FSM reset, and counts output strobes until the user is complete. It sits between the uplink control plane and the LLR datapath, which owns the IQ and noise FIFO reads.

## Interface
Parameters:
- MAX_USERS, 8: table depth; must be a power of two, 2..16.
- FSM_RST_CYCLES, 2: cycles `o_rx_fsm_rstn` is held low before each user, 1..15.

Ports:
- `i_core_clk`  in  1  — sole clock.
- `i_rx_rstn`  in  1  — asynchronous active-low reset.
- `i_cfg_wr_en`  in  1  — table write strobe.
- `i_cfg_wr_addr`  in  log2(MAX_USERS)  — table entry.
- `i_cfg_re_amounts`  in  16  — user RE count.
- `i_cfg_iq_noise_rate`  in  16  — REs per noise sample.
- `i_sym_start`  in  1  — one-cycle pulse that starts a symbol.
- `i_user_num`  in  5  — users this symbol, sampled at `i_sym_start`.
- `i_data_strobe`  in  1  — datapath output strobe; each strobe carries 2 REs.
- `o_rx_fsm_rstn`  out  1  — datapath FSM reset, active-low.
- `o_cur_user_re_amounts`  out  16  — to datapath.
- `o_user_iq_noise_rate`  out  16  — to datapath.
- `o_user_idx`  out  log2(MAX_USERS)  — current user.
- `o_busy`  out  1  — a symbol is in progress.
- `o_user_done`  out  1  — pulse when a user completes or is skipped.
- `o_sym_done`  out  1  — pulse after the last user.
- `o_err_cfg`  out  1  — pulse when a user is skipped for a bad entry.
- `o_err_strobe`  out  1  — pulse on an unexpected strobe.

## Operation
- Table: MAX_USERS × 32-bit registers, written in any state.
  - A write to the entry currently in RUN does not affect the latched outputs; it takes effect next symbol.
- States: IDLE, LOAD, FRST, RUN, NEXT, DONE.
- IDLE: on `i_sym_start`, sample `i_user_num`.
  - 0, or greater than MAX_USERS: pulse `o_sym_done` next cycle and stay IDLE (no busy).
  - Otherwise: idx=0, go to LOAD.
- LOAD (1 cycle): latch the table entry into `o_cur_user_re_amounts` / `o_user_iq_noise_rate`.
  - Compute expected strobes = (re_amounts+1)>>1, 17-bit.
  - If re_amounts==0 or rate==0: pulse `o_err_cfg`, go to NEXT.
  - Else go to FRST.
- FRST: drive `o_rx_fsm_rstn`=0 for exactly FSM_RST_CYCLES cycles, then go to RUN. Outputs stay stable throughout.
- RUN: `o_rx_fsm_rstn`=1; count `i_data_strobe`. When count+strobe reaches expected, go to NEXT.
- NEXT (1 cycle): pulse `o_user_done`. If idx==num-1, go to DONE; else idx+1, go to LOAD.
- DONE (1 cycle): pulse `o_sym_done`, go to IDLE.
- `o_err_strobe`: pulses for any `i_data_strobe` outside RUN. That strobe is not counted.
- `i_sym_start` while busy is ignored; no error is flagged.

## Timing
- Reset values:
  - FSM IDLE; `o_rx_fsm_rstn`=0.
  - All counts, idx, and data outputs 0; all pulses and `o_busy` 0.
  - Table entries cleared to 0.
  - `o_rx_fsm_rstn` goes to 1 the first cycle after reset release while in IDLE.
- The datapath is held in FSM reset only during FRST and device reset.
- `o_busy`=1 in LOAD, FRST, RUN and NEXT; 0 in IDLE and DONE.
- Latency, good user: `i_sym_start` at cycle 0 → LOAD at 1 → FRST at 2..1+FSM_RST_CYCLES → RUN.
- The strobe that completes a user is seen in RUN; NEXT follows the cycle after, with `o_user_done` in that NEXT cycle.
  - The next LOAD follows at +1, so the inter-user gap is FSM_RST_CYCLES+2 cycles.
- Skipped user: LOAD → NEXT, 2 cycles.
- Asynchronous reset mid-symbol aborts immediately:
  - No `o_sym_done`.
  - `o_rx_fsm_rstn` is asserted low asynchronously.
- All outputs are registered.

## Test plan
- Table {0: re=1797, rate=6}, num=1; send 899 strobes in RUN → `o_user_done` after strobe 899, `o_sym_done` 2 cycles later. The FSM reset low lasts exactly 2 cycles; outputs read 1797 and 6 throughout.
- Three users with re=4, 5, 2 and rate=6; strobes sent back-to-back → 2, 3, 1 strobes per user. `o_user_idx` sequence 0, 1, 2; three `o_user_done` pulses, one `o_sym_done`.
- User 1 has re=0 → `o_err_cfg` pulse, no FSM reset for user 1, users 0 and 2 complete normally.
- `i_data_strobe` in IDLE and in FRST → `o_err_strobe` each time; user count unaffected. `i_sym_start` during RUN is ignored.
- `i_user_num`=0, then `i_user_num`=MAX_USERS+1 → `o_sym_done` one cycle after each start; `o_busy` stays 0.
- Assert reset mid-RUN at strobe 400 of 899, release, restart → count restarts from 0; `o_sym_done` only after 899 strobes.
